// File: rtl/monitor_display_pkg.sv
// Shared segment codes, default stability window and sample type for the
// seven-segment score monitor and its display encoder.
package monitor_display_pkg;

  // Default number of consecutive identical samples before a digit is accepted.
  localparam int STABLE_CYCLES_DEFAULT = 16;

  // Active-low segment codes, bit order {a,b,c,d,e,f,g}.
  localparam logic [6:0] SEG_ZERO  = 7'h01;
  localparam logic [6:0] SEG_ONE   = 7'h4F;
  localparam logic [6:0] SEG_TWO   = 7'h12;
  localparam logic [6:0] SEG_THREE = 7'h06;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // One observation of the multiplexed bus: which digit, and what it shows.
  typedef struct packed {
    logic [1:0] idx;
    logic [6:0] code;
  } sample_t;

endpackage

// File: rtl/monitor_display_decodificador.sv
// Combinational seven-segment decoder for the score digits 0..3.
// Blank and every other pattern report legal = 0.
module decodificador_siete_seg
  import monitor_display_pkg::*;
(
  input  logic [6:0] code,
  output logic [1:0] value,
  output logic       legal
);

  // Map a segment pattern onto its numeric value.
  always_comb begin
    value = 2'd0;
    legal = 1'b0;
    case (code)
      SEG_ZERO:  begin value = 2'd0; legal = 1'b1; end
      SEG_ONE:   begin value = 2'd1; legal = 1'b1; end
      SEG_TWO:   begin value = 2'd2; legal = 1'b1; end
      SEG_THREE: begin value = 2'd3; legal = 1'b1; end
      default:   begin value = 2'd0; legal = 1'b0; end
    endcase
  end

endmodule

// File: rtl/monitor_display.sv
// Score monitor for a multiplexed four-digit seven-segment display.
// A digit is accepted once the same (digit, pattern) pair has been seen on
// STABLE_CYCLES consecutive cycles; digit 0 feeds PunA, digit 2 feeds PunB.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ESPERA    | no run in progress; next valid sample starts a run
//   CONTANDO  | counting consecutive identical samples of the reference
//   CAPTURADO | run already accepted; identical samples are ignored
module monitor_display
  import monitor_display_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic [6:0] displaytotal,
  input  logic       Switch0,
  input  logic       Switch1,
  input  logic       Switch2,
  input  logic       Switch3,
  output logic [1:0] PunA,
  output logic [1:0] PunB,
  output logic       Valido,
  output logic       Nuevo,
  output logic       ErrorSeg
);

  localparam logic [1:0] ESPERA    = 2'd0;
  localparam logic [1:0] CONTANDO  = 2'd1;
  localparam logic [1:0] CAPTURADO = 2'd2;

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [1:0] state;
  logic [7:0] cnt;
  sample_t    ref_sample;
  logic       seen_a;
  logic       seen_b;

  logic [3:0] sel;
  logic       sample_valid;
  sample_t    cur;
  logic       same;
  logic [7:0] cnt_inc;
  logic       hit;
  logic [1:0] dec_value;
  logic       dec_legal;

  assign sel = ~{Switch3, Switch2, Switch1, Switch0};

  // Resolve which digit is selected; only a single low select is a sample.
  always_comb begin
    sample_valid = 1'b1;
    cur.idx      = 2'd0;
    cur.code     = displaytotal;
    case (sel)
      4'b0001: cur.idx = 2'd0;
      4'b0010: cur.idx = 2'd1;
      4'b0100: cur.idx = 2'd2;
      4'b1000: cur.idx = 2'd3;
      default: sample_valid = 1'b0;
    endcase
  end

  assign same    = (cur == ref_sample);
  assign cnt_inc = (cnt >= STABLE_CNT) ? STABLE_CNT : cnt + 8'd1;
  assign hit     = (state == CONTANDO) && sample_valid && same && (cnt_inc == STABLE_CNT);

  decodificador_siete_seg u_dec (
    .code  (displaytotal),
    .value (dec_value),
    .legal (dec_legal)
  );

  // Run tracking: count identical samples and move between the three states.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state      <= ESPERA;
      cnt        <= 8'd0;
      ref_sample <= '0;
    end else if (!sample_valid) begin
      state <= ESPERA;
      cnt   <= 8'd0;
    end else begin
      case (state)
        CONTANDO: begin
          if (same) begin
            cnt <= cnt_inc;
            if (hit) state <= CAPTURADO;
          end else begin
            ref_sample <= cur;
            cnt        <= 8'd1;
          end
        end
        CAPTURADO: begin
          if (!same) begin
            ref_sample <= cur;
            cnt        <= 8'd1;
            state      <= CONTANDO;
          end
        end
        default: begin
          ref_sample <= cur;
          cnt        <= 8'd1;
          state      <= CONTANDO;
        end
      endcase
    end
  end

  // Acceptance: update scores and flags, or flag a bad pattern.
  always_ff @(posedge clock) begin
    if (Reset) begin
      PunA     <= 2'd0;
      PunB     <= 2'd0;
      seen_a   <= 1'b0;
      seen_b   <= 1'b0;
      Nuevo    <= 1'b0;
      ErrorSeg <= 1'b0;
    end else begin
      Nuevo    <= 1'b0;
      ErrorSeg <= 1'b0;
      if (hit) begin
        case (cur.idx)
          2'd0: begin
            if (dec_legal) begin
              PunA   <= dec_value;
              seen_a <= 1'b1;
              Nuevo  <= !seen_a || (dec_value != PunA);
            end else begin
              ErrorSeg <= 1'b1;
            end
          end
          2'd2: begin
            if (dec_legal) begin
              PunB   <= dec_value;
              seen_b <= 1'b1;
              Nuevo  <= !seen_b || (dec_value != PunB);
            end else begin
              ErrorSeg <= 1'b1;
            end
          end
          default: begin
            // Digits 1 and 3 are expected to stay dark.
            ErrorSeg <= (displaytotal != SEG_BLANK);
          end
        endcase
      end
    end
  end

  assign Valido = seen_a && seen_b;

endmodule

// File: tb/tb_monitor_display.sv
// Self-checking bench for monitor_display: directed scenarios followed by
// randomized holds, compared every cycle against a run-length reference model.
module tb_monitor_display;

  localparam int STABLE = 16;

  logic       clock = 1'b0;
  logic       Reset;
  logic [6:0] displaytotal;
  logic       Switch0, Switch1, Switch2, Switch3;
  logic [1:0] PunA, PunB;
  logic       Valido, Nuevo, ErrorSeg;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  int         run_len;
  int         r_idx;
  logic [6:0] r_code;
  logic [1:0] m_a, m_b;
  logic       m_seen_a, m_seen_b, m_nuevo, m_err;

  monitor_display #(.STABLE_CYCLES(STABLE)) dut (
    .clock        (clock),
    .Reset        (Reset),
    .displaytotal (displaytotal),
    .Switch0      (Switch0),
    .Switch1      (Switch1),
    .Switch2      (Switch2),
    .Switch3      (Switch3),
    .PunA         (PunA),
    .PunB         (PunB),
    .Valido       (Valido),
    .Nuevo        (Nuevo),
    .ErrorSeg     (ErrorSeg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp_v, $time);
    end
  endtask

  // Numeric meaning of a segment pattern: 0..3, or -1 for blank/illegal.
  function automatic int seg_value(input logic [6:0] c);
    case (c)
      7'h01:   return 0;
      7'h4F:   return 1;
      7'h12:   return 2;
      7'h06:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_accept(input int idx, input logic [6:0] c);
    int v;
    v = seg_value(c);
    if (idx == 0 || idx == 2) begin
      if (v < 0) m_err = 1'b1;
      else if (idx == 0) begin
        m_nuevo  = !m_seen_a || (m_a != v[1:0]);
        m_a      = v[1:0];
        m_seen_a = 1'b1;
      end else begin
        m_nuevo  = !m_seen_b || (m_b != v[1:0]);
        m_b      = v[1:0];
        m_seen_b = 1'b1;
      end
    end else begin
      m_err = (c != 7'h7F);
    end
  endtask

  // One clock: apply inputs, advance the model, compare all outputs.
  task automatic step(input logic [3:0] sw, input logic [6:0] c, input logic rst);
    int nlow;
    int idx;
    Reset        = rst;
    displaytotal = c;
    {Switch3, Switch2, Switch1, Switch0} = sw;
    @(posedge clock);
    m_nuevo = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      run_len = 0; m_a = 0; m_b = 0; m_seen_a = 0; m_seen_b = 0;
    end else begin
      nlow = 0;
      idx  = 0;
      for (int i = 0; i < 4; i++) if (!sw[i]) begin nlow++; idx = i; end
      if (nlow != 1) run_len = 0;
      else begin
        if (run_len > 0 && idx == r_idx && c == r_code) begin
          if (run_len < 1000) run_len++;
        end else begin
          run_len = 1;
          r_idx   = idx;
          r_code  = c;
        end
        if (run_len == STABLE) model_accept(idx, c);
      end
    end
    #1;
    check("PunA", PunA, m_a);
    check("PunB", PunB, m_b);
    check("Valido", {1'b0, Valido}, {1'b0, m_seen_a && m_seen_b});
    check("Nuevo", {1'b0, Nuevo}, {1'b0, m_nuevo});
    check("ErrorSeg", {1'b0, ErrorSeg}, {1'b0, m_err});
    check("Nuevo_and_ErrorSeg", {1'b0, Nuevo && ErrorSeg}, 2'd0);
  endtask

  task automatic hold(input logic [3:0] sw, input logic [6:0] c, input int n);
    for (int k = 0; k < n; k++) step(sw, c, 1'b0);
  endtask

  initial begin
    logic [6:0] codes [6];
    logic [3:0] sw;
    logic [6:0] c;
    int         r;
    int         n_nuevo;

    run_len = 0; r_idx = 0; r_code = '0;
    m_a = 0; m_b = 0; m_seen_a = 0; m_seen_b = 0; m_nuevo = 0; m_err = 0;
    Reset = 1'b1; displaytotal = 7'h7F;
    {Switch3, Switch2, Switch1, Switch0} = 4'hF;

    // Reset state.
    step(4'hF, 7'h7F, 1'b1);
    step(4'b1110, 7'h12, 1'b1);
    check("reset_PunA", PunA, 2'd0);

    // Digit 0 shows "2" for 16 cycles: PunA=2 with a Nuevo pulse on edge 16.
    hold(4'b1110, 7'h12, 15);
    check("pre_accept_nuevo", {1'b0, Nuevo}, 2'd0);
    step(4'b1110, 7'h12, 1'b0);
    check("dir_PunA_2", PunA, 2'd2);
    check("dir_nuevo_a", {1'b0, Nuevo}, 2'd1);
    check("dir_valido_0", {1'b0, Valido}, 2'd0);

    // Digit 2 shows "3": PunB=3, Valido rises; a repeated run gives no Nuevo.
    hold(4'b1011, 7'h06, 16);
    check("dir_PunB_3", PunB, 2'd3);
    check("dir_valido_1", {1'b0, Valido}, 2'd1);
    n_nuevo = 0;
    for (int k = 0; k < 16; k++) begin
      step(4'b1011, 7'h06, 1'b0);
      if (Nuevo) n_nuevo++;
    end
    check("dir_no_second_nuevo", n_nuevo[1:0], 2'd0);

    // 15 + gap + 15 never reaches the window.
    hold(4'b1110, 7'h4F, 15);
    step(4'b1111, 7'h4F, 1'b0);
    hold(4'b1110, 7'h4F, 15);
    check("dir_gap_PunA", PunA, 2'd2);

    // Lit pattern on digit 1 is an error; scores untouched.
    hold(4'b1101, 7'h4F, 16);
    check("dir_err_digit1", {1'b0, ErrorSeg}, 2'd1);
    step(4'b1101, 7'h4F, 1'b0);
    check("dir_err_once", {1'b0, ErrorSeg}, 2'd0);

    // Two selects low never count.
    hold(4'b1010, 7'h01, 40);

    // Reset on the would-be acceptance edge, then a full fresh run is needed.
    hold(4'b1110, 7'h01, 15);
    step(4'b1110, 7'h01, 1'b1);
    check("rst_override_nuevo", {1'b0, Nuevo}, 2'd0);
    hold(4'b1110, 7'h01, 15);
    check("rst_partial_valido", {1'b0, Valido}, 2'd0);
    step(4'b1110, 7'h01, 1'b0);
    check("rst_full_run_nuevo", {1'b0, Nuevo}, 2'd1);

    // Illegal code on digit 2.
    hold(4'b1011, 7'h55, 16);

    // Randomized holds.
    codes[0] = 7'h01; codes[1] = 7'h4F; codes[2] = 7'h12;
    codes[3] = 7'h06; codes[4] = 7'h7F; codes[5] = 7'h00;
    for (int seg = 0; seg < 300; seg++) begin
      r = int'($urandom_range(0, 19));
      if (r < 14)      sw = ~(4'b0001 << $urandom_range(0, 3));
      else if (r < 16) sw = 4'hF;
      else             sw = 4'($urandom);
      r = int'($urandom_range(0, 6));
      c = (r == 6) ? 7'($urandom) : codes[r % 6];
      if ($urandom_range(0, 24) == 0) step(sw, c, 1'b1);
      hold(sw, c, int'($urandom_range(1, 22)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/monitor_display.md
MONITOR_DISPLAY -- requirements
Module: monitor_display

Interface
REQ-001 Parameter STABLE_CYCLES, default 16, meaning consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 clock  input  1  system clock; all inputs are synchronous to it.
REQ-003 Reset  input  1  reset, synchronous and active-high.
REQ-004 displaytotal  input  7  multiplexed segment bus {a,b,c,d,e,f,g}, active-low.
REQ-005 Switch0, Switch1, Switch2, Switch3  input  1 each  digit selects, active-low; Switch0 selects digit 0.
REQ-006 PunA  output  2  score decoded from digit 0.
REQ-007 PunB  output  2  score decoded from digit 2.
REQ-008 Valido  output  1  high once digit 0 and digit 2 have each been accepted at least once since reset.
REQ-009 Nuevo  output  1  one-cycle pulse when an accepted value differs from the held PunA or PunB, or is the first acceptance for that digit.
REQ-010 ErrorSeg  output  1  one-cycle pulse on an accepted illegal pattern.

Function
REQ-011 Legal codes SHALL be: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, blank=7'h7F.
REQ-012 Each cycle SHALL be a valid sample only if exactly one Switch input is low; the sample value is the pair (digit index, displaytotal).
REQ-013 A cycle with zero or with two or more Switch inputs low SHALL clear the stability counter and return the FSM to ESPERA.
REQ-014 FSM states SHALL be ESPERA, CONTANDO and CAPTURADO.
REQ-015 ESPERA: a valid sample SHALL load the reference pair, set the counter to 1 and go to CONTANDO.
REQ-016 CONTANDO: a sample equal to the reference SHALL increment the counter; a different valid sample SHALL reload the reference with counter=1 and stay in CONTANDO.
REQ-017 On the edge that registers the STABLE_CYCLES-th consecutive identical sample, the digit SHALL be accepted and the FSM SHALL go to CAPTURADO; there is no additional latency.
REQ-018 CAPTURADO: an identical sample SHALL hold the state with no further acceptance (one acceptance per run); a different valid sample SHALL behave as in ESPERA.
REQ-019 Acceptance of digit 0 or digit 2 with a legal code 0..3 SHALL update PunA or PunB on the same edge and set that digit's seen flag.
REQ-020 Acceptance of digit 0 or 2 with blank or an illegal code SHALL pulse ErrorSeg and leave the score unchanged.
REQ-021 Acceptance of digit 1 or 3 SHALL produce no output when the code is blank, and SHALL pulse ErrorSeg otherwise.
REQ-022 Nuevo and ErrorSeg SHALL never be asserted in the same cycle.
REQ-023 Valido SHALL be the AND of the two seen flags and SHALL stay high until reset.
REQ-024 The counter SHALL saturate at STABLE_CYCLES and never wrap.

Reset
REQ-025 While Reset=1, on each edge: PunA=0, PunB=0, Valido=0, Nuevo=0, ErrorSeg=0, seen flags=0, counter=0, state=ESPERA.
REQ-026 Reset SHALL override any concurrent acceptance; a run in progress is discarded, and sampling restarts on the first edge after Reset falls.

Structure
REQ-027 The segment codes and the default STABLE_CYCLES value SHALL live in a shared include file used by both the display encoder and this block.
REQ-028 Code-to-value decoding SHALL be one combinational sub-module, decodificador_siete_seg (inputs: 7-bit code; outputs: 2-bit value and a legal flag).

Verification
REQ-029 Hold Switch0=0 with displaytotal=7'h12 for 16 cycles -> PunA=2 and Nuevo pulses on the 16th edge; Valido stays 0.
REQ-030 Then hold Switch2=0 with 7'h06 for 16 cycles -> PunB=3, Nuevo pulses, Valido=1; repeat the run -> no second Nuevo.
REQ-031 Hold Switch0=0 with 7'h4F for 15 cycles, then one cycle with all Switch inputs high, then 15 more cycles -> PunA unchanged, no pulse.
REQ-032 Hold Switch1=0 with 7'h4F for 16 cycles -> ErrorSeg pulses once; PunA and PunB unchanged.
REQ-033 Switch0=0 and Switch2=0 together for 40 cycles -> no acceptance.
REQ-034 Assert Reset on the edge where an acceptance would occur -> all outputs 0; the next run needs a full 16 samples.
